// File: rtl/multicycle_controller.sv
// Main sequencing FSM and ALU decoder for the multicycle ARM datapath.
// Every output is a combinational function of the current state and the latched instruction fields.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    output logic               pcs,
    output logic               next_pc,
    output logic               reg_w,
    output logic               mem_w,
    output logic [1:0]         flag_w,
    output logic               ir_write,
    output logic               adr_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic [STATE_W-1:0] state_dbg
);

    // state    | meaning
    // FETCH    | load IR from mem[PC], PC <= PC + 4
    // DECODE   | read registers, precompute PC + 8
    // MEMADR   | compute load/store address
    // MEMRD    | read data memory
    // MEMWB    | write loaded data to Rd
    // MEMWR    | write data memory
    // EXECUTER | ALU op with register operand B
    // EXECUTEI | ALU op with immediate operand B
    // ALUWB    | write ALU result to Rd
    // BRANCH   | compute branch target, request PC load
    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMRD    = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWR    = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t     state_q;
    logic       alu_op;
    logic       branch;
    logic [1:0] dec_ctrl;
    logic       dec_valid;
    logic       dec_arith;
    logic       no_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state_q <= MEMADR;
                        2'b00:   state_q <= funct[5] ? EXECUTEI : EXECUTER;
                        2'b10:   state_q <= BRANCH;
                        default: state_q <= FETCH;
                    endcase
                end
                MEMADR:   state_q <= funct[0] ? MEMRD : MEMWR;
                MEMRD:    state_q <= MEMWB;
                EXECUTER: state_q <= ALUWB;
                EXECUTEI: state_q <= ALUWB;
                default:  state_q <= FETCH;
            endcase
        end
    end

    // Decoded purely from funct so ALUWB can still see no_write after alu_op drops.
    always_comb begin
        dec_ctrl  = 2'b00;
        dec_valid = 1'b1;
        dec_arith = 1'b0;
        no_write  = 1'b0;
        case (funct[4:1])
            4'b0100: dec_arith = 1'b1;
            4'b0010: begin dec_ctrl = 2'b01; dec_arith = 1'b1; end
            4'b0000: dec_ctrl = 2'b10;
            4'b1100: dec_ctrl = 2'b11;
            4'b1010: begin dec_ctrl = 2'b01; dec_arith = 1'b1; no_write = 1'b1; end
            default: begin dec_valid = 1'b0; no_write = 1'b1; end
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ALUWB: reg_w = ~no_write;
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_control = alu_op ? dec_ctrl : 2'b00;
    assign flag_w      = (alu_op && dec_valid) ? {funct[0], funct[0] & dec_arith} : 2'b00;
    assign pcs         = branch | (reg_w & (rd == 4'hF));
    assign imm_src     = op;
    assign reg_src     = {op == 2'b01, op == 2'b10};
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions checked against an
// instruction-level reference model (state sequence plus per-state control outputs).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       pcs, next_pc, reg_w, mem_w, ir_write, adr_src, alu_src_a;
    logic [1:0] flag_w, alu_src_b, result_src, alu_control, imm_src, reg_src;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
        .pcs(pcs), .next_pc(next_pc), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w),
        .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
        .reg_src(reg_src), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [20:0] obs_vec;
    assign obs_vec = {pcs, next_pc, reg_w, mem_w, flag_w, ir_write, adr_src, alu_src_a,
                      alu_src_b, result_src, alu_control, imm_src, reg_src};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sequence of states an instruction visits, starting at FETCH.
    function automatic void build_seq(input logic [1:0] o, input logic [5:0] f, ref int q[$]);
        q = {0, 1};
        if (o == 2'b01) begin
            q.push_back(2);
            if (f[0]) begin q.push_back(3); q.push_back(4); end
            else q.push_back(5);
        end else if (o == 2'b00) begin
            q.push_back(f[5] ? 7 : 6);
            q.push_back(8);
        end else if (o == 2'b10) begin
            q.push_back(9);
        end
    endfunction

    // Expected control outputs for one state of a given instruction.
    function automatic logic [20:0] model(input int s, input logic [1:0] o,
                                          input logic [5:0] f, input logic [3:0] r);
        logic ir = 0, npc = 0, rw = 0, mw = 0, as = 0, asa = 0, br = 0;
        logic [1:0] fw = 0, asb = 0, rs = 0, ac = 0;
        bit valid, arith, writes;
        valid  = 1; arith = 0; writes = 1;
        if (f[4:1] == 4'b0100) arith = 1;
        else if (f[4:1] == 4'b0010) begin ac = 1; arith = 1; end
        else if (f[4:1] == 4'b0000) ac = 2;
        else if (f[4:1] == 4'b1100) ac = 3;
        else if (f[4:1] == 4'b1010) begin ac = 1; arith = 1; writes = 0; end
        else begin valid = 0; writes = 0; end
        if (s == 0) begin ir = 1; npc = 1; asa = 1; asb = 2; rs = 2; end
        if (s == 1) begin asa = 1; asb = 2; rs = 2; end
        if (s == 2) asb = 1;
        if (s == 3) as = 1;
        if (s == 4) begin rs = 1; rw = 1; end
        if (s == 5) begin as = 1; mw = 1; end
        if (s == 7 || s == 9) asb = 1;
        if (s == 9) begin rs = 2; br = 1; end
        if (s == 8) rw = writes;
        if (s != 6 && s != 7) ac = 0;
        if ((s == 6 || s == 7) && valid) fw = {f[0], f[0] & arith};
        return {br | (rw & (r == 4'd15)), npc, rw, mw, fw, ir, as, asa, asb, rs, ac,
                o, (o == 2'b01), (o == 2'b10)};
    endfunction

    // Called just after a rising edge that lands in FETCH; returns just after the edge back into FETCH.
    // abort_at >= 0 pulses reset on arrival in that state and returns mid-cycle.
    task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input int abort_at);
        int q[$];
        build_seq(o, f, q);
        op = o; funct = f; rd = r;
        foreach (q[i]) begin
            if (q[i] == abort_at) begin
                check($sformatf("%s pre_reset_state", name), state_dbg, q[i]);
                #1 reset = 1'b0;
                #1;
                check($sformatf("%s async_reset_state", name), state_dbg, 0);
                check($sformatf("%s async_reset_reg_w", name), reg_w, 0);
                check($sformatf("%s async_reset_mem_w", name), mem_w, 0);
                check($sformatf("%s async_reset_outs", name), obs_vec, model(0, o, f, r));
                #1 reset = 1'b1;
                return;
            end
            @(negedge clk);
            check($sformatf("%s state_step%0d", name, i), state_dbg, q[i]);
            check($sformatf("%s outs_state%0d", name, q[i]), obs_vec, model(q[i], o, f, r));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] codes [5];
        logic [3:0] code;
        logic [5:0] f;
        logic [3:0] r;
        codes[0] = 4'b0100; codes[1] = 4'b0010; codes[2] = 4'b0000;
        codes[3] = 4'b1100; codes[4] = 4'b1010;

        reset = 1'b0; op = 2'b00; funct = 6'b001000; rd = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", state_dbg, 0);
        check("reset_outs", obs_vec, model(0, 2'b00, 6'b001000, 4'b0001));
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr("add_r", 2'b00, 6'b001000, 4'b0001, -1);
        run_instr("ldr", 2'b01, 6'b011001, 4'b0010, -1);
        run_instr("str", 2'b01, 6'b011000, 4'b0011, -1);
        run_instr("cmp_i_pc", 2'b00, 6'b110101, 4'b1111, -1);
        run_instr("branch", 2'b10, 6'b000000, 4'b0000, -1);
        run_instr("add_pc", 2'b00, 6'b001000, 4'b1111, -1);
        run_instr("undef", 2'b11, 6'b101011, 4'b1111, -1);
        run_instr("ldr_pc", 2'b01, 6'b011001, 4'b1111, -1);
        run_instr("ldr_abort", 2'b01, 6'b011001, 4'b0100, 3);
        run_instr("ldr_after_reset", 2'b01, 6'b011001, 4'b0100, -1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) != 0) code = codes[$urandom_range(0, 4)];
            else code = 4'($urandom);
            f = {1'($urandom), code, 1'($urandom)};
            r = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            run_instr($sformatf("rand%0d", k), 2'($urandom), f, r, -1);
        end

        @(negedge clk);
        check("final_fetch", state_dbg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
